// File: rtl/stream_mux_rr.sv
// N:1 stream multiplexer with round-robin grant and a registered output stage.
// Define MUX_FIXED_PRIO_EN for a fixed lowest-index-first grant (no pointer state).
module stream_mux_rr #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_sel
);

  logic [WIDTH-1:0] word [CHANNELS];
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic [SEL_W-1:0] search_base;
  logic [SEL_W-1:0] grant_idx;
  logic             load_en;

  assign load_en = !rst && (!out_valid_reg || out_ready) && (|in_valid);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign word[gi]     = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = load_en && (grant_idx == SEL_W'(gi));
    end
  endgenerate

`ifdef MUX_FIXED_PRIO_EN
  // A search that always starts just after the last index is plain lowest-first priority.
  assign search_base = SEL_W'(CHANNELS - 1);
`else
  logic [SEL_W-1:0] ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= SEL_W'(CHANNELS - 1);
    end else if (load_en) begin
      ptr_reg <= grant_idx;
    end
  end

  assign search_base = ptr_reg;
`endif

  // Walk from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    int               pos;
    logic [SEL_W-1:0] pos_idx;
    pos       = 0;
    pos_idx   = '0;
    grant_idx = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      pos = int'(search_base) + k;
      if (pos >= CHANNELS) begin
        pos = pos - CHANNELS;
      end
      pos_idx = SEL_W'(pos);
      if (in_valid[pos_idx]) begin
        grant_idx = pos_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else if (load_en) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= word[grant_idx];
      out_sel_reg   <= grant_idx;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a per-cycle reference model predicts grants,
// and a separate monitor compares every presented output word against the queue.
module tb_stream_mux_rr;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;

  stream_mux_rr #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   sel_log[$];
  bit   log_en    = 1'b0;
  int   checks    = 0;
  int   passes    = 0;
  int   model_ptr = N - 1;
  bit   model_ov  = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endfunction

  // First valid channel scanning upward from ptr+1 with wrap-around.
  function automatic int ref_grant(logic [N-1:0] v, int p);
    int            idx;
    logic [SW-1:0] ix;
`ifdef MUX_FIXED_PRIO_EN
    p = N - 1;
`endif
    for (int k = 1; k <= N; k++) begin
      idx = (p + k) % N;
      ix  = SW'(idx);
      if (v[ix]) return idx;
    end
    return -1;
  endfunction

  // Reference model: predicts in_ready / out_valid and queues each accepted word.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    bit           load;
    int           g;
    exp_ready = '0;
    g         = 0;
    load      = !rst && (!model_ov || out_ready) && (in_valid != '0);
    if (load) begin
      g         = ref_grant(in_valid, model_ptr);
      exp_ready = N'(1) << g;
    end
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(model_ov));
    if (rst) begin
      model_ov  = 1'b0;
      model_ptr = N - 1;
      exp_q.delete();
    end else if (load) begin
      exp_q.push_back('{sel: g, data: W'(in_data >> (g * W))});
      model_ptr = g;
      model_ov  = 1'b1;
    end else if (out_ready) begin
      model_ov = 1'b0;
    end
  end

  // Monitor: every presented word must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got sel=%0d data=%0h, expected no word", out_sel, out_data);
      end else begin
        check("out_sel", 32'(out_sel), 32'(exp_q[0].sel));
        check("out_data", 32'(out_data), 32'(exp_q[0].data));
        if (out_ready) begin
          if (log_en) sel_log.push_back(int'(out_sel));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int exp_seq[5];
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    step(2);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_sel", 32'(out_sel), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    // Full contention
    in_data = {4'h3, 4'hC, 4'h2, 4'hD};
    in_valid = 4'hF; out_ready = 1'b1; log_en = 1'b1;
    step(5);
    in_valid = '0;
    step(1);
    log_en = 1'b0;
`ifdef MUX_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    check("contention_count", 32'(sel_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < sel_log.size(); i++) check("contention_sel", 32'(sel_log[i]), 32'(exp_seq[i]));

    // Back-pressure
    in_valid = 4'b0001; out_ready = 1'b0;
    step(1);
    step(3);
    out_ready = 1'b1;
    step(1);
    in_valid = '0;
    step(2);

    // Wrap and skip
    in_valid = 4'b1000; step(1);
    in_valid = 4'b0010; step(1);
    in_valid = 4'b0101; step(1);
    in_valid = '0;      step(2);

    // Drain to empty
    in_valid = 4'b0100; step(1);
    in_valid = '0;      step(3);

    // Mid-operation reset with a stalled word
    in_valid = 4'b0001; out_ready = 1'b0; step(2);
    in_valid = 4'hF; rst = 1'b1; step(2);
    rst = 1'b0; out_ready = 1'b1; step(1);
    in_valid = '0; step(2);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = N'($urandom);
      in_data   = (N*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      if (rst) out_ready = 1'b0;
      step(1);
    end
    rst = 1'b0; in_valid = '0; out_ready = 1'b1;
    step(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
